// File: rtl/div_pkg.sv
// Shared types and width helpers for the radix-2 unsigned divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_t;

  localparam int DIV_DATA_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DIV_DATA_WIDTH);

endpackage

// File: rtl/div_clz.sv
// Combinational leading-zero counter; an all-zero input yields DATA_WIDTH.
module div_clz
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]            din,
  output logic [cnt_width(DATA_WIDTH):0]   lz
);

  localparam int LZ_W = cnt_width(DATA_WIDTH);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    lz = (LZ_W+1)'(DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (din[i]) lz = (LZ_W+1)'(DATA_WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/radix2_unsigned_divider.sv
// Sequential restoring radix-2 unsigned divider, one quotient bit per cycle.
// Optional leading-zero skip enabled by defining DIV_EARLY_TERMINATE_EN.
//
// state  | meaning
// IDLE   | waiting for start; results from the last operation held
// RUN    | one restoring iteration per cycle until count reaches zero
// FINISH | done pulse; results valid
module radix2_unsigned_divider
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  done,
  output logic                  divisor_is_zero,
  output logic                  busy
);

  localparam int CW = cnt_width(DATA_WIDTH);

  div_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] q_q, rem_q, div_q;
  logic [CW-1:0]         cnt_q;
  logic                  dz_q;
  logic [DATA_WIDTH:0]   r_shift, diff;

`ifdef DIV_EARLY_TERMINATE_EN
  logic [CW:0] lz;

  div_clz #(.DATA_WIDTH(DATA_WIDTH)) u_clz (
    .din (dividend),
    .lz  (lz)
  );
`endif

  // Full remainder is shifted so divisors above 2^(W-1) restore correctly.
  assign r_shift = {rem_q, q_q[DATA_WIDTH-1]};
  assign diff    = r_shift - {1'b0, div_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) state_d = FINISH;
`ifdef DIV_EARLY_TERMINATE_EN
          else if (dividend == '0) state_d = FINISH;
`endif
          else state_d = RUN;
        end
      end
      RUN:     if (cnt_q == '0) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done = 1'b0;
    busy = 1'b1;
    case (state_q)
      IDLE:    busy = 1'b0;
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            div_q <= divisor;
            if (divisor == '0) begin
              q_q   <= '1;
              rem_q <= dividend;
              dz_q  <= 1'b1;
            end else begin
              dz_q  <= 1'b0;
              rem_q <= '0;
`ifdef DIV_EARLY_TERMINATE_EN
              if (dividend == '0) begin
                q_q <= '0;
              end else begin
                q_q   <= dividend << lz;
                cnt_q <= CW'(DATA_WIDTH - 1 - int'(lz));
              end
`else
              q_q   <= dividend;
              cnt_q <= CW'(DATA_WIDTH - 1);
`endif
            end
          end
        end
        RUN: begin
          if (!diff[DATA_WIDTH]) rem_q <= diff[DATA_WIDTH-1:0];
          else                   rem_q <= r_shift[DATA_WIDTH-1:0];
          q_q <= {q_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign quotient        = q_q;
  assign remainder       = rem_q;
  assign divisor_is_zero = dz_q;

endmodule
